// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter:
// FSM states, register offsets, STATUS bit positions and the bus lane swap.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [3:0] TXDATA_OFF = 4'h0;
  localparam logic [3:0] STATUS_OFF = 4'h4;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 8;

  localparam int OVF_CLR_BIT = 27;

  // The core places CPU byte 0 on lanes [31:24]; this maps between the two views.
  function automatic logic [31:0] byte_swap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular TX FIFO with wrap-bit pointers; the head word is presented
// combinationally so the transmitter can pop and load in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // Full is judged on pre-edge pointers, so a push coinciding with a pop while full is lost.
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS window, TX FIFO, 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_byte_mask,
  input  logic        bus_we,
  output logic [31:0] bus_rdata,
  output logic        sel_hit,
  output logic        tx,
  output logic        tx_empty_irq
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  logic [3:0]        offset;
  logic              write_qual;
  logic              write_qual_reg;
  logic              write_edge;
  logic              push;
  logic              drop;
  logic              clr_ovf;
  logic              overflow_reg;

  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  logic [3:0]        count_disp;
  logic              pop;

  tx_state_t         state_reg, state_next;
  logic [BAUD_W-1:0] baud_reg, baud_next;
  logic [2:0]        bit_reg, bit_next;
  logic [7:0]        data_reg, data_next;
  logic              tx_reg, tx_next;
  logic              baud_last;

  logic [31:0]       status_v;
  logic              unused_bits;

  assign unused_bits = ^{bus_wdata[23:0], bus_byte_mask[2:0]};

  // ---------------- bus decode ----------------
  assign sel_hit    = (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign offset     = bus_addr[3:0];
  assign write_qual = sel_hit & bus_we & bus_byte_mask[3];
  // A core may hold a store for several cycles; only its first cycle pushes.
  assign write_edge = write_qual & ~write_qual_reg;
  assign push       = write_edge & (offset == TXDATA_OFF);
  assign drop       = push & fifo_full;
  assign clr_ovf    = write_qual & (offset == STATUS_OFF) & bus_wdata[OVF_CLR_BIT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_qual_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      write_qual_reg <= write_qual;
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (clr_ovf) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus_wdata[31:24]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------- STATUS read path ----------------
  generate
    if (CNT_W > 4) begin : g_cnt_sat
      assign count_disp = (fifo_count > CNT_W'(15)) ? 4'hF : fifo_count[3:0];
    end else begin : g_cnt_pad
      assign count_disp = 4'(fifo_count);
    end
  endgenerate

  always_comb begin
    status_v                           = '0;
    status_v[STAT_BUSY]                = (state_reg != IDLE);
    status_v[STAT_FULL]                = fifo_full;
    status_v[STAT_EMPTY]               = fifo_empty;
    status_v[STAT_OVERFLOW]            = overflow_reg;
    status_v[STAT_COUNT_LSB +: 4]      = count_disp;
  end

  assign bus_rdata    = (sel_hit && offset == STATUS_OFF) ? byte_swap(status_v) : 32'h0;
  assign tx_empty_irq = fifo_empty & (state_reg == IDLE);

  // ---------------- transmit FSM ----------------
  assign baud_last = (baud_reg == BAUD_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    data_next  = data_reg;
    tx_next    = 1'b1;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          data_next  = fifo_dout;
          baud_next  = '0;
          bit_next   = '0;
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (baud_last) begin
          baud_next  = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      DATA: begin
        tx_next = data_reg[bit_reg];
        if (baud_last) begin
          baud_next = '0;
          if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_next = ^data_reg;
        if (baud_last) begin
          baud_next  = '0;
          state_next = STOP;
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
`endif
      STOP: begin
        if (baud_last) begin
          baud_next  = '0;
          state_next = IDLE;
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // tx is registered from the current state, so the line is glitch-free and lags state by one clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      data_reg  <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      data_reg  <= data_next;
      tx_reg    <= tx_next;
    end
  end

  assign tx = tx_reg;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4) with a
// line receiver model; honours UART_TX_PARITY_EN like the design.
module tb_mmio_uart_tx;

  localparam int          CPB    = 4;
  localparam logic [31:0] TXADDR = 32'h1000_0000;
  localparam logic [31:0] STADDR = 32'h1000_0004;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] bus_addr = 32'h0;
  logic [31:0] bus_wdata = 32'h0;
  logic [3:0]  bus_byte_mask = 4'h0;
  logic        bus_we = 1'b0;
  logic [31:0] bus_rdata;
  logic        sel_hit;
  logic        tx;
  logic        tx_empty_irq;

  int n_checks = 0;
  int n_fail = 0;
  int reset_seen = 0;
  int frame_err = 0;
  logic [7:0] rx_q[$];
`ifdef UART_TX_PARITY_EN
  logic       par_q[$];
`endif

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4),
    .BASE_ADDR    (32'h1000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_byte_mask (bus_byte_mask),
    .bus_we        (bus_we),
    .bus_rdata     (bus_rdata),
    .sel_hit       (sel_hit),
    .tx            (tx),
    .tx_empty_irq  (tx_empty_irq)
  );

  always #5 clk = ~clk;

  always @(posedge reset) reset_seen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] mask, input int n);
    bus_addr      = addr;
    bus_wdata     = data;
    bus_byte_mask = mask;
    bus_we        = 1'b1;
    repeat (n) @(negedge clk);
    bus_we = 1'b0;
    @(negedge clk);
    $display("write addr=0x%08h data=0x%08h mask=%b cycles=%0d", addr, data, mask, n);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data, output logic hit);
    bus_addr = addr;
    bus_we   = 1'b0;
    #1;
    data = bus_rdata;
    hit  = sel_hit;
    $display("read  addr=0x%08h data=0x%08h hit=%b", addr, data, hit);
  endtask

  task automatic wait_rx(input int n, input string tag);
    int guard;
    guard = 0;
    while (rx_q.size() < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk(tag, rx_q.size(), n);
  endtask

  // Cycle-exact check of one frame, starting on the first start-bit cycle.
  task automatic frame(input logic [7:0] b, input string tag);
    logic [10:0] seq;
    logic [3:0]  nib;
    int          nb;
    int          waited;
`ifdef UART_TX_PARITY_EN
    seq = {1'b1, ^b, b, 1'b0};
    nb  = 11;
`else
    seq = {2'b11, b, 1'b0};
    nb  = 10;
`endif
    waited = 0;
    while (tx !== 1'b0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_start_seen"}, 32'(waited < 400), 32'd1);
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < CPB; c++) begin
        nib[c] = tx;
        @(negedge clk);
      end
      chk($sformatf("%s_bit%0d", tag, k), 32'(nib), seq[k] ? 32'hF : 32'h0);
    end
    $display("frame 0x%02h checked cycle by cycle", b);
  endtask

  // Receiver model: samples mid-bit, discards frames interrupted by reset.
  initial begin : rx_monitor
    logic [7:0] b;
    logic       good;
    int         rst_mark;
`ifdef UART_TX_PARITY_EN
    logic       par;
`endif
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        rst_mark = reset_seen;
        good     = 1'b1;
        repeat (2) @(negedge clk);
        if (tx !== 1'b0) good = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        par = tx;
`endif
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) good = 1'b0;
        if (rst_mark == reset_seen) begin
          if (good) begin
            rx_q.push_back(b);
`ifdef UART_TX_PARITY_EN
            par_q.push_back(par);
`endif
            $display("rx    byte=0x%02h", b);
          end else begin
            frame_err++;
          end
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] rdata;
    logic        hit;
    logic        tx_low;

    // reset state
    repeat (3) @(negedge clk);
    chk("tx_in_reset", 32'(tx), 32'd1);
    reset = 1'b0;
    chk("tx_after_reset", 32'(tx), 32'd1);
    chk("irq_after_reset", 32'(tx_empty_irq), 32'd1);
    rd(STADDR, rdata, hit);
    chk("status_reset", rdata, 32'h0400_0000);
    chk("sel_hit_status", 32'(hit), 32'd1);

    // single frame 0x55, latency and exact bit timing
    wr(TXADDR, 32'h5500_0000, 4'b1000, 1);
    rd(STADDR, rdata, hit);
    chk("status_busy", rdata, 32'h0500_0000);
    chk("tx_latency_1clk", 32'(tx), 32'd1);
    @(negedge clk);
    chk("tx_latency_2clk", 32'(tx), 32'd0);
    frame(8'h55, "f55");
    chk("irq_after_frame", 32'(tx_empty_irq), 32'd1);
    rd(STADDR, rdata, hit);
    chk("status_idle", rdata, 32'h0400_0000);
    chk("rx_count_1", rx_q.size(), 1);
    chk("rx_55", 32'(rx_q[0]), 32'h55);

    // held strobe pushes once; non-TXDATA/unmasked/out-of-window writes ignored
    wr(TXADDR, 32'hA500_0000, 4'b1000, 5);
    rd(STADDR, rdata, hit);
    chk("status_held", rdata, 32'h0500_0000);
    wr(32'h1000_0008, 32'h7700_0000, 4'b1000, 1);
    wr(32'h2000_0000, 32'h7800_0000, 4'b1000, 1);
    wr(TXADDR, 32'h6600_0000, 4'b0111, 1);
    rd(32'h1000_0008, rdata, hit);
    chk("rd_other_off", rdata, 32'h0);
    rd(32'h2000_0004, rdata, hit);
    chk("rd_outside", rdata, 32'h0);
    chk("sel_hit_outside", 32'(hit), 32'd0);
    wait_rx(2, "rx_count_2");
    tx_low = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (tx === 1'b0) tx_low = 1'b1;
    end
    chk("no_extra_frame", 32'(tx_low), 32'd0);
    chk("rx_count_2b", rx_q.size(), 2);
    chk("rx_a5", 32'(rx_q[1]), 32'hA5);

    // six quick writes: one popped, four queued, sixth dropped
    for (int k = 1; k <= 6; k++) begin
      wr(TXADDR, {k[7:0], 24'h0}, 4'b1000, 1);
    end
    rd(STADDR, rdata, hit);
    chk("status_full_ovf", rdata, 32'h0B04_0000);
    chk("irq_busy", 32'(tx_empty_irq), 32'd0);
    wr(STADDR, 32'h0800_0000, 4'b1000, 1);
    rd(STADDR, rdata, hit);
    chk("status_ovf_clr", rdata, 32'h0304_0000);
    wait_rx(7, "rx_count_7");
    repeat (60) @(negedge clk);
    chk("rx_count_7b", rx_q.size(), 7);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rx_seq%0d", k + 1), 32'(rx_q[2 + k]), 32'(k + 1));
    end
    rd(STADDR, rdata, hit);
    chk("status_drained", rdata, 32'h0400_0000);

    // reset during data bit 3 of 0x00 with 0x33 queued
    wr(TXADDR, 32'h0000_0000, 4'b1000, 1);
    wr(TXADDR, 32'h3300_0000, 4'b1000, 1);
    repeat (16) @(negedge clk);
    chk("tx_bit3_low", 32'(tx), 32'd0);
    reset = 1'b1;
    #1;
    chk("tx_async_reset", 32'(tx), 32'd1);
    chk("irq_async_reset", 32'(tx_empty_irq), 32'd1);
    rd(STADDR, rdata, hit);
    chk("status_mid_reset", rdata, 32'h0400_0000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tx_low = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tx === 1'b0) tx_low = 1'b1;
    end
    chk("no_frame_after_reset", 32'(tx_low), 32'd0);
    chk("rx_count_after_reset", rx_q.size(), 7);

`ifdef UART_TX_PARITY_EN
    wr(TXADDR, 32'h0700_0000, 4'b1000, 1);
    wr(TXADDR, 32'h0300_0000, 4'b1000, 1);
    wait_rx(9, "rx_count_par");
    chk("rx_07", 32'(rx_q[7]), 32'h07);
    chk("rx_03", 32'(rx_q[8]), 32'h03);
    chk("par_07", 32'(par_q[7]), 32'd1);
    chk("par_03", 32'(par_q[8]), 32'd0);
`endif

    chk("frame_errors", frame_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
